// File: rtl/parallel_io_bank.sv
// parallel_io_bank: memory-mapped parallel output and synchronized input channels.
// Define PIO_IRQ_EN to build the change-detect PEND/MASK/IRQ logic.
module parallel_io_bank #(
    parameter int         N_PORTS   = 2,
    parameter int         WIDTH     = 32,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       EN,
    input  logic [7:0]                 Address,
    input  logic [31:0]                RegData,
    input  logic [31:0]                MemData,
    input  logic [N_PORTS*WIDTH-1:0]   DataIN,
    output logic [N_PORTS*WIDTH-1:0]   DataOUT,
    output logic [31:0]                LoadData,
    output logic                       IRQ
);

    typedef logic [N_PORTS-1:0][WIDTH-1:0] chan_t;

    localparam logic [7:0] PEND_ADDR = 8'(BASE_ADDR + 8 * N_PORTS);
    localparam logic [7:0] MASK_ADDR = 8'(BASE_ADDR + 8 * N_PORTS + 4);

    chan_t              out_q, out_d;
    chan_t              sync1_q, sync1_d;
    chan_t              sync2_q, sync2_d;
    logic [N_PORTS-1:0] out_hit, in_hit;
    logic               pend_hit, mask_hit;
    logic [N_PORTS-1:0] pend_rd, mask_rd;

    // Address decode of the per-channel OUT/IN registers
    always_comb begin
        out_hit = '0;
        in_hit  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            out_hit[k] = (Address == 8'(BASE_ADDR + 8 * k));
            in_hit[k]  = (Address == 8'(BASE_ADDR + 8 * k + 4));
        end
    end

    assign pend_hit = (Address == PEND_ADDR);
    assign mask_hit = (Address == MASK_ADDR);

    // Output register writes and the two-stage input synchronizer
    always_comb begin
        out_d   = out_q;
        sync1_d = DataIN;
        sync2_d = sync1_q;
        for (int k = 0; k < N_PORTS; k++) begin
            if (EN && out_hit[k]) begin
                out_d[k] = RegData[WIDTH-1:0];
            end
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            out_q   <= out_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign DataOUT = out_q;

`ifdef PIO_IRQ_EN
    chan_t              hist_q, hist_d;
    logic [N_PORTS-1:0] pend_q, pend_d;
    logic [N_PORTS-1:0] mask_q, mask_d;
    logic [N_PORTS-1:0] chg, clr;
    logic [1:0]         fill_q, fill_d;
    logic               irq_q, irq_d;
    logic               filling;

    // Change detect, W1C pending (set wins), mask and interrupt.
    // For two cycles after reset history tracks stage two in parallel
    // so that inputs already stable do not look like a change.
    always_comb begin
        filling = ~fill_q[1];
        fill_d  = {fill_q[0], 1'b1};
        hist_d  = filling ? sync2_d : sync2_q;
        chg     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            chg[k] = |(sync2_q[k] ^ hist_q[k]);
        end
        clr    = (EN && pend_hit) ? RegData[N_PORTS-1:0] : '0;
        pend_d = (pend_q & ~clr) | (chg & {N_PORTS{~filling}});
        mask_d = (EN && mask_hit) ? RegData[N_PORTS-1:0] : mask_q;
        irq_d  = |(pend_q & mask_q);
    end

    // Interrupt state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            fill_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            fill_q <= fill_d;
            irq_q  <= irq_d;
        end
    end

    assign pend_rd = pend_q;
    assign mask_rd = mask_q;
    assign IRQ     = irq_q;
`else
    assign pend_rd = '0;
    assign mask_rd = '0;
    assign IRQ     = 1'b0;
`endif

    // Load mux: mapped registers zero-extended, otherwise memory data
    always_comb begin
        LoadData = MemData;
        for (int k = 0; k < N_PORTS; k++) begin
            if (out_hit[k]) begin
                LoadData = 32'(out_q[k]);
            end
            if (in_hit[k]) begin
                LoadData = 32'(sync2_q[k]);
            end
        end
        if (pend_hit) begin
            LoadData = 32'(pend_rd);
        end
        if (mask_hit) begin
            LoadData = 32'(mask_rd);
        end
    end

endmodule

// File: tb/tb_parallel_io_bank.sv
// tb_parallel_io_bank: directed vector bench for parallel_io_bank.
// Expectations adapt to whether PIO_IRQ_EN is defined.
module tb_parallel_io_bank;

`ifdef PIO_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        EN;
    logic [7:0]  Address;
    logic [31:0] RegData;
    logic [31:0] MemData;
    logic [63:0] DataIN;
    logic [63:0] DataOUT;
    logic [31:0] LoadData;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    parallel_io_bank #(
        .N_PORTS  (2),
        .WIDTH    (32),
        .BASE_ADDR(8'hE0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .EN      (EN),
        .Address (Address),
        .RegData (RegData),
        .MemData (MemData),
        .DataIN  (DataIN),
        .DataOUT (DataOUT),
        .LoadData(LoadData),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  addr;
        logic [31:0] regd;
        logic [31:0] mem;
        logic [31:0] exp_load;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'hE8, 32'hDEADBEEF, 32'h11111111, 32'h0,
                     {32'hDEADBEEF, 32'h0}};
        vecs[1]  = '{1'b0, 8'hE8, 32'h12345678, 32'h0, 32'hDEADBEEF,
                     {32'hDEADBEEF, 32'h0}};
        vecs[2]  = '{1'b1, 8'hE0, 32'hCAFEF00D, 32'h5, 32'h0,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[3]  = '{1'b1, 8'hE4, 32'hFFFFFFFF, 32'h7, 32'h0,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[4]  = '{1'b1, 8'hEC, 32'hFFFFFFFF, 32'h7, 32'h0,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[5]  = '{1'b1, 8'h10, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[6]  = '{1'b1, 8'hE2, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[7]  = '{1'b0, 8'hE0, 32'h0, 32'h1, 32'hCAFEF00D,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[8]  = '{1'b1, 8'hDC, 32'h0, 32'h2, 32'h2,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[9]  = '{1'b1, 8'hF8, 32'h0, 32'h3, 32'h3,
                     {32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[10] = '{1'b1, 8'hE8, 32'h1, 32'h0, 32'hDEADBEEF,
                     {32'h1, 32'hCAFEF00D}};
        vecs[11] = '{1'b0, 8'hF0, 32'hFFFFFFFF, 32'h9, 32'h0,
                     {32'h1, 32'hCAFEF00D}};
        vecs[12] = '{1'b0, 8'hF4, 32'h0, 32'h9, 32'h0,
                     {32'h1, 32'hCAFEF00D}};

        rst = 1'b0;
        EN = 1'b0;
        Address = 8'hE0;
        RegData = '0;
        MemData = '0;
        DataIN = '0;

        // Reset state
        tick();
        tick();
        chk("rst_dataout", DataOUT, 64'h0);
        chk("rst_irq", 64'(IRQ), 64'h0);
        chk("rst_out0_read", 64'(LoadData), 64'h0);
        rst = 1'b1;
        tick();
        tick();
        tick();

        // Table of single-cycle register accesses
        for (int i = 0; i < 13; i++) begin
            EN = vecs[i].en;
            Address = vecs[i].addr;
            RegData = vecs[i].regd;
            MemData = vecs[i].mem;
            #1;
            chk($sformatf("vec%0d_load", i), 64'(LoadData),
                64'(vecs[i].exp_load));
            tick();
            chk($sformatf("vec%0d_out", i), DataOUT, vecs[i].exp_out);
        end

        // Input synchronizer latency
        EN = 1'b0;
        Address = 8'hE4;
        DataIN[31:0] = 32'h0000A5A5;
        #1;
        chk("in0_lat0", 64'(LoadData), 64'h0);
        tick();
        chk("in0_lat1", 64'(LoadData), 64'h0);
        tick();
        chk("in0_lat2", 64'(LoadData), 64'h0000A5A5);
        Address = 8'h10;
        MemData = 32'h13579BDF;
        #1;
        chk("unmapped_mem", 64'(LoadData), 64'h13579BDF);
        tick();
        Address = 8'hF0;
        #1;
        chk("a_pend_set", 64'(LoadData), HAS_IRQ ? 64'h1 : 64'h0);
        EN = 1'b1;
        RegData = 32'h3;
        tick();
        EN = 1'b0;
        #1;
        chk("a_pend_clr", 64'(LoadData), 64'h0);

        // Mask load, unused bits read zero
        EN = 1'b1;
        Address = 8'hF4;
        RegData = 32'hFFFFFFFD;
        tick();
        EN = 1'b0;
        #1;
        chk("mask_rd", 64'(LoadData), HAS_IRQ ? 64'h1 : 64'h0);

        // Toggle bit 0: pend after 3 edges, irq one later, W1C
        Address = 8'hF0;
        DataIN[0] = 1'b0;
        tick();
        tick();
        chk("c_pend_early", 64'(LoadData), 64'h0);
        tick();
        chk("c_pend_set", 64'(LoadData), HAS_IRQ ? 64'h1 : 64'h0);
        chk("c_irq_lag", 64'(IRQ), 64'h0);
        tick();
        chk("c_irq_set", 64'(IRQ), HAS_IRQ ? 64'h1 : 64'h0);
        EN = 1'b1;
        RegData = 32'h1;
        tick();
        EN = 1'b0;
        #1;
        chk("c_pend_w1c", 64'(LoadData), 64'h0);
        chk("c_irq_hold", 64'(IRQ), HAS_IRQ ? 64'h1 : 64'h0);
        tick();
        chk("c_irq_clr", 64'(IRQ), 64'h0);

        // Channel 1: set wins over a same-cycle W1C
        DataIN[32] = 1'b1;
        tick();
        tick();
        tick();
        chk("d_pend1_set", 64'(LoadData), HAS_IRQ ? 64'h2 : 64'h0);
        chk("d_irq_masked", 64'(IRQ), 64'h0);
        DataIN[32] = 1'b0;
        tick();
        tick();
        EN = 1'b1;
        RegData = 32'h2;
        tick();
        EN = 1'b0;
        #1;
        chk("d_set_wins", 64'(LoadData), HAS_IRQ ? 64'h2 : 64'h0);
        EN = 1'b1;
        tick();
        EN = 1'b0;
        #1;
        chk("d_pend1_clr", 64'(LoadData), 64'h0);

        // Async reset with state loaded and a write in flight
        EN = 1'b1;
        Address = 8'hE0;
        RegData = 32'hFFFFFFFF;
        tick();
        Address = 8'hF4;
        RegData = 32'h3;
        tick();
        EN = 1'b0;
        Address = 8'hF0;
        DataIN = {32'h00000010, 32'h0000A5A5};
        tick();
        tick();
        tick();
        chk("e_pend_both", 64'(LoadData), HAS_IRQ ? 64'h3 : 64'h0);
        tick();
        chk("e_irq_pre", 64'(IRQ), HAS_IRQ ? 64'h1 : 64'h0);
        chk("e_out_pre", DataOUT, {32'h1, 32'hFFFFFFFF});
        EN = 1'b1;
        Address = 8'hE8;
        RegData = 32'h55555555;
        #1;
        rst = 1'b0;
        #1;
        chk("e_rst_out", DataOUT, 64'h0);
        chk("e_rst_irq", 64'(IRQ), 64'h0);
        chk("e_rst_out1_rd", 64'(LoadData), 64'h0);
        EN = 1'b0;
        Address = 8'hF0;
        #1;
        chk("e_rst_pend", 64'(LoadData), 64'h0);
        Address = 8'hF4;
        #1;
        chk("e_rst_mask", 64'(LoadData), 64'h0);
        EN = 1'b1;
        Address = 8'hE8;
        tick();
        chk("e_write_discard", DataOUT, 64'h0);
        #2;
        rst = 1'b1;
        EN = 1'b0;
        Address = 8'hF0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("e_no_spurious", 64'(LoadData), 64'h0);
        chk("e_irq_post", 64'(IRQ), 64'h0);
        chk("e_out_post", DataOUT, 64'h0);
        Address = 8'hE4;
        #1;
        chk("e_in0_refill", 64'(LoadData), 64'h0000A5A5);
        Address = 8'hEC;
        #1;
        chk("e_in1_refill", 64'(LoadData), 64'h00000010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_io_bank.md
PARALLEL_IO_BANK -- requirements
Module: parallel_io_bank

Interface
REQ-001 The block SHALL take parameter N_PORTS, default 2, meaning the number of independent I/O channels (legal 1..8).
REQ-002 The block SHALL take parameter WIDTH, default 32, meaning the bits per channel (legal 1..32).
REQ-003 The block SHALL take parameter BASE_ADDR, default 8'hE0, meaning the byte address of channel 0; BASE_ADDR + 8*N_PORTS + 4 SHALL be <= 8'hFF.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 EN  input  1  store enable from the datapath, qualifies writes.
REQ-007 Address  input  8  byte address from the datapath.
REQ-008 RegData  input  32  store data from the register file.
REQ-009 MemData  input  32  load data from data memory.
REQ-010 DataIN  input  N_PORTS*WIDTH  external inputs, channel k at bits [k*WIDTH +: WIDTH].
REQ-011 DataOUT  output  N_PORTS*WIDTH  registered external outputs, same packing.
REQ-012 LoadData  output  32  load data returned to the register file.
REQ-013 IRQ  output  1  level interrupt request.

Function
REQ-014 The address map SHALL be: OUT_k at BASE_ADDR+8k (R/W); IN_k at BASE_ADDR+8k+4 (RO); PEND at BASE_ADDR+8*N_PORTS (R/W1C); MASK at PEND+4 (R/W).
REQ-015 On a rising clk edge with EN=1 and Address=OUT_k, OUT_k SHALL load RegData[WIDTH-1:0]; DataOUT SHALL reflect OUT_k with one-cycle latency.
REQ-016 Writes with EN=1 to IN_k or to unmapped addresses SHALL have no effect on block state.
REQ-017 Each DataIN channel SHALL pass through a 2-flop synchronizer; IN_k reads SHALL return the second-stage value, i.e. 2 clk latency from a DataIN change.
REQ-018 LoadData SHALL be combinational: the selected register zero-extended to 32 bits when Address matches a mapped register, otherwise MemData.
REQ-019 Any bit difference between the second-stage sample and a third-stage history register of channel k SHALL set PEND[k] on the next edge.
REQ-020 A write with EN=1 to PEND SHALL clear each PEND[k] where RegData[k]=1; bits with RegData[k]=0 SHALL be unchanged.
REQ-021 If a change on channel k is detected in the same cycle as a W1C of PEND[k], PEND[k] SHALL end set (set wins).
REQ-022 A write with EN=1 to MASK SHALL load RegData[N_PORTS-1:0]; unused bits of PEND/MASK SHALL read 0.
REQ-023 IRQ SHALL be registered and equal OR over k of (PEND[k] AND MASK[k]) from the previous cycle.
REQ-024 Multi-bit simultaneous input changes on one channel SHALL set PEND[k] once; no event counting.

Reset
REQ-025 On rst=0, regardless of clk, OUT_k, synchronizer stages, history, PEND, MASK and IRQ SHALL clear to 0; DataOUT SHALL be 0.
REQ-026 After rst deasserts, the first history compare SHALL NOT raise PEND for inputs stable at their post-reset value while the pipeline fills (history loads with the second stage in parallel for 2 cycles).
REQ-027 Reset asserted mid-write SHALL discard the write.

Configuration
REQ-028 With macro PIO_IRQ_EN defined, REQ-019..REQ-024 and REQ-026 SHALL be implemented.
REQ-029 Without PIO_IRQ_EN, history, PEND and MASK SHALL not exist, PEND/MASK addresses SHALL read 0 and ignore writes, and IRQ SHALL be tied 0.

Verification
REQ-030 N_PORTS=2, WIDTH=32: write 32'hDEADBEEF to 8'hE8 with EN=1 -> next cycle DataOUT[63:32]=32'hDEADBEEF, DataOUT[31:0]=0; same write with EN=0 -> no change.
REQ-031 DataIN[31:0]=32'h0000A5A5, read 8'hE4 -> LoadData=0 for 2 cycles then 32'h0000A5A5; read 8'h10 -> LoadData=MemData.
REQ-032 MASK=2'b01, toggle DataIN bit 0 -> PEND=2'b01 after 3 edges, IRQ=1 one cycle later; W1C 32'h1 to 8'hF0 -> PEND=0, IRQ=0 next cycle.
REQ-033 Toggle DataIN bit 32 in the cycle a W1C of PEND[1] lands -> PEND[1] remains 1.
REQ-034 Pulse rst=0 between clk edges with OUT_0=32'hFFFFFFFF, PEND=2'b11 -> DataOUT, PEND, IRQ read 0 immediately; no spurious PEND after release with DataIN held constant at nonzero.
REQ-035 Build without PIO_IRQ_EN: input toggles -> IRQ stays 0, reads of 8'hF0/8'hF4 return 0.
